// File: rtl/uart_debug_monitor.sv
// UART command engine: host reads probe channels, controls CPU halt/run/step, selects display channel.
// One command at a time; bytes that arrive while a response is being sent wait in the UART until IDLE.
module uart_debug_monitor #(
  parameter int N_CH         = 8,
  parameter int DATA_W       = 32,
  parameter int STEP_CYC     = 2,
  parameter int ARG_TIMEOUT  = 50000000,
  parameter bit RUN_AT_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] probes,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_re,
  output logic [7:0]             tx_data,
  output logic                   tx_we,
  input  logic                   tx_busy,
  output logic                   cpu_run,
  output logic                   cpu_en,
  output logic [3:0]             disp_sel,
  output logic [15:0]            disp_value,
  output logic                   cmd_err
);

  localparam int NHEX  = DATA_W / 4;
  localparam int TO_W  = $clog2(ARG_TIMEOUT + 1);
  localparam int IDX_W = $clog2(NHEX + 3);

  typedef enum logic [2:0] {IDLE, ARG_WAIT, EXEC, TX_LOAD, TX_GUARD, TX_WAIT} state_t;
  typedef enum logic [1:0] {RESP_HEX, RESP_OK, RESP_ERR} resp_t;

  state_t            state;
  resp_t             resp;
  logic              rx_skip;
  logic [7:0]        cmd;
  logic [7:0]        arg;
  logic              arg_to;
  logic [TO_W-1:0]   arg_cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [DATA_W-1:0] shreg;
  logic [7:0]        step_cnt;
  logic [7:0]        cur_char;
  logic [7:0]        hex_ch;
  logic [3:0]        nib;
  logic [4:0]        arg_dec;
  logic              arg_ok;

  // Padded to 16 entries so any 4-bit channel index is in range.
  logic [DATA_W-1:0] ch [16];
  for (genvar k = 0; k < 16; k++) begin : g_ch
    if (k < N_CH) begin : g_on
      assign ch[k] = probes[k*DATA_W +: DATA_W];
    end else begin : g_off
      assign ch[k] = '0;
    end
  end

  // Returns {valid, value} for an ASCII hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return {1'b1, b[3:0]};
    if (b >= "A" && b <= "F") return {1'b1, 4'(b - 8'h37)};
    if (b >= "a" && b <= "f") return {1'b1, 4'(b - 8'h57)};
    return 5'd0;
  endfunction

  assign arg_dec = hex_val(arg);
  assign arg_ok  = arg_dec[4] && !arg_to && ({1'b0, arg_dec[3:0]} < 5'(N_CH));
  assign cpu_en  = cpu_run | (step_cnt != 8'd0);

  always_comb begin
    nib      = shreg[DATA_W-1 -: 4];
    hex_ch   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    last_idx = (resp == RESP_HEX) ? IDX_W'(NHEX + 1) : IDX_W'(2);
    if (idx == last_idx)                      cur_char = 8'h0A;
    else if (idx == last_idx - IDX_W'(1))     cur_char = 8'h0D;
    else if (resp == RESP_HEX)                cur_char = hex_ch;
    else if (resp == RESP_OK)                 cur_char = "K";
    else                                      cur_char = "?";
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      resp     <= RESP_OK;
      rx_re    <= 1'b0;
      rx_skip  <= 1'b0;
      tx_we    <= 1'b0;
      tx_data  <= '0;
      cpu_run  <= RUN_AT_RESET;
      disp_sel <= '0;
      cmd_err  <= 1'b0;
      cmd      <= '0;
      arg      <= '0;
      arg_to   <= 1'b0;
      arg_cnt  <= '0;
      idx      <= '0;
      shreg    <= '0;
      step_cnt <= '0;
    end else begin
      rx_re   <= 1'b0;
      tx_we   <= 1'b0;
      rx_skip <= 1'b0;
      if (step_cnt != 8'd0) step_cnt <= step_cnt - 8'd1;
      case (state)
        IDLE: if (rx_valid && !rx_skip) begin
          rx_re   <= 1'b1;
          rx_skip <= 1'b1;
          cmd     <= rx_data;
          arg_to  <= 1'b0;
          arg_cnt <= '0;
          if (rx_data == "R" || rx_data == "D") state <= ARG_WAIT;
          else if (!(rx_data == 8'h0D || rx_data == 8'h0A || rx_data == 8'h20)) state <= EXEC;
        end
        // An argument on the final timeout cycle takes priority over the timeout.
        ARG_WAIT: if (rx_valid && !rx_skip) begin
          rx_re   <= 1'b1;
          rx_skip <= 1'b1;
          arg     <= rx_data;
          state   <= EXEC;
        end else if (arg_cnt == TO_W'(ARG_TIMEOUT - 1)) begin
          arg_to <= 1'b1;
          state  <= EXEC;
        end else begin
          arg_cnt <= arg_cnt + TO_W'(1);
        end
        EXEC: begin
          idx   <= '0;
          resp  <= RESP_OK;
          state <= TX_LOAD;
          case (cmd)
            "R": if (arg_ok) begin
              resp  <= RESP_HEX;
              shreg <= ch[arg_dec[3:0]];
            end else begin
              resp    <= RESP_ERR;
              cmd_err <= 1'b1;
            end
            "D": if (arg_ok) disp_sel <= arg_dec[3:0];
                 else begin
                   resp    <= RESP_ERR;
                   cmd_err <= 1'b1;
                 end
            "H": begin
              cpu_run  <= 1'b0;
              step_cnt <= '0;
            end
            "G": cpu_run <= 1'b1;
            "S": if (!cpu_run) step_cnt <= 8'(STEP_CYC);
            "C": cmd_err <= 1'b0;
            default: begin
              resp    <= RESP_ERR;
              cmd_err <= 1'b1;
            end
          endcase
        end
        TX_LOAD: if (!tx_busy) begin
          tx_data <= cur_char;
          tx_we   <= 1'b1;
          state   <= TX_GUARD;
        end
        TX_GUARD: state <= TX_WAIT;
        TX_WAIT: if (!tx_busy) begin
          if (idx == last_idx) begin
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
            if (resp == RESP_HEX) shreg <= {shreg[DATA_W-5:0], 4'h0};
            state <= TX_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_value <= '0;
    else     disp_value <= ch[disp_sel][15:0];
  end

endmodule

// File: tb/tb_uart_debug_monitor.sv
// Directed bench for uart_debug_monitor with a small UART rx/tx model.
module tb_uart_debug_monitor;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [255:0]  probes = '0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_re;
  logic [7:0]    tx_data;
  logic          tx_we;
  logic          tx_busy = 1'b0;
  logic          cpu_run;
  logic          cpu_en;
  logic [3:0]    disp_sel;
  logic [15:0]   disp_value;
  logic          cmd_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_re = 0;
  int n_we = 0;
  int bad_we = 0;
  int en_cnt = 0;
  int busy_cnt = 0;
  int we_mark;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  uart_debug_monitor #(
    .N_CH(8), .DATA_W(32), .STEP_CYC(2), .ARG_TIMEOUT(100), .RUN_AT_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .probes(probes),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_re(rx_re),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .cpu_run(cpu_run), .cpu_en(cpu_en),
    .disp_sel(disp_sel), .disp_value(disp_value), .cmd_err(cmd_err)
  );

  // UART transmitter model: busy for three cycles after each write.
  always @(posedge clk) begin
    #1;
    if (rx_re) n_re++;
    if (cpu_en) en_cnt++;
    if (rst) begin
      busy_cnt = 0;
    end else if (tx_we) begin
      if (tx_busy) bad_we++;
      txq.push_back(tx_data);
      n_we++;
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (rx_re) got = 1'b1;
    end
    rx_valid = 1'b0;
    chk("rx_consumed", {31'b0, got}, 32'd1);
  endtask

  task automatic expect_resp(input string tag, input string s);
    logic [7:0] obs;
    for (int i = 0; i < 600 && txq.size() < s.len(); i++) tick();
    repeat (20) tick();
    chk({tag, "_count"}, txq.size(), s.len());
    for (int j = 0; j < s.len(); j++) begin
      obs = (j < txq.size()) ? txq[j] : 8'h00;
      chk($sformatf("%s_char%0d", tag, j), {24'b0, obs}, {24'b0, s[j]});
    end
    txq.delete();
  endtask

  initial begin
    // Reset values while rst is held.
    repeat (3) tick();
    chk("rst_cpu_run", {31'b0, cpu_run}, 1);
    chk("rst_cpu_en", {31'b0, cpu_en}, 1);
    chk("rst_disp_sel", {28'b0, disp_sel}, 0);
    chk("rst_disp_value", {16'b0, disp_value}, 0);
    chk("rst_cmd_err", {31'b0, cmd_err}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    chk("rst_tx_we", n_we, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Read channel 3; the probe changes mid-response but the snapshot holds.
    probes[3*32 +: 32] = 32'hDEADBEEF;
    probes[5*32 +: 32] = 32'hAAAA1234;
    send_byte("R");
    send_byte("3");
    for (int i = 0; i < 100 && txq.size() < 1; i++) tick();
    probes[3*32 +: 32] = 32'h01234567;
    expect_resp("read_ch3", "DEADBEEF\015\012");
    chk("no_we_while_busy", bad_we, 0);

    // Halt, single step, run.
    send_byte("H");
    expect_resp("halt", "K\015\012");
    chk("halt_cpu_run", {31'b0, cpu_run}, 0);
    chk("halt_cpu_en", {31'b0, cpu_en}, 0);
    en_cnt = 0;
    send_byte("S");
    expect_resp("step", "K\015\012");
    chk("step_en_cycles", en_cnt, 2);
    chk("step_en_after", {31'b0, cpu_en}, 0);
    send_byte("G");
    expect_resp("go", "K\015\012");
    chk("go_cpu_run", {31'b0, cpu_run}, 1);
    chk("go_cpu_en", {31'b0, cpu_en}, 1);

    // Display select, register latency, and an out-of-range channel.
    send_byte("D");
    send_byte("5");
    expect_resp("disp5", "K\015\012");
    chk("disp5_sel", {28'b0, disp_sel}, 5);
    chk("disp5_value", {16'b0, disp_value}, 32'h1234);
    probes[5*32 +: 16] = 16'hBEEF;
    chk("disp_latency_old", {16'b0, disp_value}, 32'h1234);
    tick();
    chk("disp_latency_new", {16'b0, disp_value}, 32'hBEEF);
    send_byte("D");
    send_byte("9");
    expect_resp("disp9", "?\015\012");
    chk("disp9_cmd_err", {31'b0, cmd_err}, 1);
    chk("disp9_sel_kept", {28'b0, disp_sel}, 5);

    // Clear, then argument timeout, then clear again.
    send_byte("C");
    expect_resp("clear1", "K\015\012");
    chk("clear1_cmd_err", {31'b0, cmd_err}, 0);
    send_byte("R");
    repeat (95) tick();
    chk("timeout_not_early", txq.size(), 0);
    expect_resp("timeout", "?\015\012");
    chk("timeout_cmd_err", {31'b0, cmd_err}, 1);
    send_byte("C");
    expect_resp("clear2", "K\015\012");
    chk("clear2_cmd_err", {31'b0, cmd_err}, 0);

    // Unknown byte, then a silently dropped CR.
    n_re = 0;
    send_byte("x");
    expect_resp("unknown", "?\015\012");
    chk("unknown_rx_re", n_re, 1);
    n_re = 0;
    send_byte(8'h0D);
    repeat (20) tick();
    chk("cr_no_resp", txq.size(), 0);
    chk("cr_rx_re", n_re, 1);

    // Reset in the middle of a response.
    send_byte("H");
    expect_resp("halt2", "K\015\012");
    send_byte("R");
    send_byte("3");
    for (int i = 0; i < 100 && txq.size() < 2; i++) tick();
    rst = 1'b1;
    we_mark = n_we;
    repeat (5) tick();
    chk("midrst_no_we", n_we, we_mark);
    chk("midrst_cpu_run", {31'b0, cpu_run}, 1);
    chk("midrst_cpu_en", {31'b0, cpu_en}, 1);
    chk("midrst_disp_sel", {28'b0, disp_sel}, 0);
    chk("midrst_cmd_err", {31'b0, cmd_err}, 0);
    chk("midrst_tx_data", {24'b0, tx_data}, 0);
    rst = 1'b0;
    repeat (30) tick();
    chk("postrst_no_we", n_we, we_mark);
    chk("final_no_we_while_busy", bad_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_debug_monitor.md
Name: uart_debug_monitor

Overview:
- UART command engine giving the host read access to N_CH probe words, CPU halt/run/single-step control, and 7-segment source selection.
- Sits between the UART (rx/tx byte handshake) and the CPU data path in the FPGA debug top.
- Supersedes the fixed PC/rx-byte display mux with host-selectable channels.
- Single clock domain: clk is the same clock as the UART and the CPU clock-enable logic.

Parameters:
N_CH, 8, number of probe channels (1..16)
DATA_W, 32, probe width in bits; multiple of 4
STEP_CYC, 2, clk cycles of cpu_en asserted per single step (1..255)
ARG_TIMEOUT, 50000000, clk cycles allowed between command byte and argument byte
RUN_AT_RESET, 1, reset value of cpu_run

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
probes  in  N_CH*DATA_W  channel k = probes[k*DATA_W +: DATA_W]
rx_data  in  8  received byte from UART
rx_valid  in  1  rx_data holds an unread byte
rx_re  out  1  one-cycle pulse that consumes rx_data
tx_data  out  8  byte to send
tx_we  out  1  one-cycle pulse that writes tx_data
tx_busy  in  1  UART transmitter busy
cpu_run  out  1  CPU free-run state
cpu_en  out  1  CPU clock enable = cpu_run | step_active
disp_sel  out  4  selected display channel
disp_value  out  16  probes[disp_sel][15:0], registered
cmd_err  out  1  sticky; set on any error response, cleared by 'C'

Behaviour:
- Reset values: rx_re=0, tx_we=0, tx_data=0, cpu_run=RUN_AT_RESET, cpu_en=RUN_AT_RESET, disp_sel=0, disp_value=0, cmd_err=0, FSM=IDLE. Reset mid-response aborts the response with no further tx_we.
- States: IDLE, ARG_WAIT, EXEC, TX_LOAD, TX_GUARD, TX_WAIT.
- RX handshake:
  - Bytes are consumed only in IDLE and ARG_WAIT.
  - When rx_valid=1, pulse rx_re for one cycle and latch rx_data.
  - The next cycle is ignored for rx_valid, which covers the UART clear latency.
- Commands are uppercase ASCII only:
  - 'R' then hex digit n: send the DATA_W/4 uppercase hex chars of channel n, MSB first, then 0x0D 0x0A.
  - 'D' then hex digit n: set disp_sel=n, then send "K\r\n".
  - 'H': cpu_run=0, then send "K\r\n".
  - 'G': cpu_run=1, then send "K\r\n".
  - 'S': if cpu_run=0, assert cpu_en for exactly STEP_CYC cycles starting the cycle after EXEC. If cpu_run=1, no effect. Either way, send "K\r\n".
  - 'C': clear cmd_err, then send "K\r\n".
  - 0x0D, 0x0A and 0x20 in IDLE: silently dropped.
  - Any other byte: send "?\r\n".
- Argument rules:
  - Accepted argument digits: '0'-'9', 'A'-'F', 'a'-'f'.
  - A non-hex argument, or a digit n >= N_CH, gets the response "?\r\n" and sets cmd_err. disp_sel is unchanged.
- Argument timeout:
  - The counter resets when entering ARG_WAIT.
  - If ARG_TIMEOUT cycles elapse with no byte, send "?\r\n", set cmd_err, and return to IDLE.
  - An argument arriving on the timeout cycle itself wins.
- Snapshot: in the EXEC cycle, the whole channel word is latched into a DATA_W shift register. All hex chars of one response come from that single sample.
- TX handshake:
  - TX_LOAD waits for tx_busy=0, drives tx_data, and pulses tx_we for one cycle.
  - TX_GUARD holds one cycle.
  - TX_WAIT waits for tx_busy=0, then advances the char index.
  - After the last char, return to IDLE.
  - tx_we is never asserted while tx_busy=1.
- Bytes arriving during a response stay in the UART; they are not consumed until IDLE.
- Step boundaries:
  - A 'G' received while a step is active lets the step complete; cpu_en stays 1 afterwards.
  - An 'H' received while a step is active cancels the remaining step cycles.
- disp_value is updated every cycle from the probes, with 1-cycle latency.
- Hex encoding: nibble 0-9 maps to 0x30+v; nibble 10-15 maps to 0x37+v.

Test Plan:
- Reset, then hold rst=1 mid-run → cpu_run=1, cpu_en=1, disp_sel=0, no tx_we, outputs at reset values.
- probes ch3=0xDEADBEEF; send 'R','3'; change ch3 during TX → tx bytes "DEADBEEF\r\n" (0x44,0x45,...,0x0D,0x0A), 10 tx_we pulses, none while tx_busy=1.
- Send 'H' → "K\r\n", cpu_run=0, cpu_en=0. Then 'S' with STEP_CYC=2 → cpu_en high exactly 2 clk cycles, then 0. Then 'G' → cpu_en=1.
- Send 'D','5' with ch5[15:0]=0x1234 → disp_sel=5, disp_value=0x1234 one cycle later. Then 'D','9' with N_CH=8 → "?\r\n", cmd_err=1, disp_sel stays 5.
- Send 'R' then nothing, with ARG_TIMEOUT=100 → "?\r\n" after 100 cycles, cmd_err=1. Then 'C' → "K\r\n", cmd_err=0.
- Send 'x' → "?\r\n". Send 0x0D → no response, exactly one rx_re pulse per byte.
